// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice resolved per stage,
// carry and group generate/propagate carried forward in registers.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iSub,
    input  logic             iCarryIn,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarryOut,
    output logic             oOverflow,
    output logic             oGen,
    output logic             oPropagate
);
    localparam int unsigned NSTAGE = WIDTH / BLOCK;

    logic w_adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum_nxt;
        logic             w_cin;
        logic             w_gin;
        logic             w_pin;
        logic             w_vin;
        logic [BLOCK-1:0] w_sa;
        logic [BLOCK-1:0] w_sb;
        logic [BLOCK-1:0] w_g;
        logic [BLOCK-1:0] w_p;
        logic [BLOCK:0]   w_c;
        logic             w_gs;
        logic             w_ps;

        logic [WIDTH-1:0] r_sum;
        logic             r_v;
        logic             r_c;
        logic             r_g;
        logic             r_p;

        if (k == 0) begin : g_head
            assign w_a      = iA;
            assign w_b      = iSub ? ~iB : iB;
            assign w_cin    = iSub | iCarryIn;
            assign w_sum_in = '0;
            // Identity values for the group accumulation.
            assign w_gin    = 1'b0;
            assign w_pin    = 1'b1;
            assign w_vin    = iValid;
        end else begin : g_tail
            assign w_a      = g_stage[k-1].g_ops.r_a;
            assign w_b      = g_stage[k-1].g_ops.r_b;
            assign w_cin    = g_stage[k-1].r_c;
            assign w_sum_in = g_stage[k-1].r_sum;
            assign w_gin    = g_stage[k-1].r_g;
            assign w_pin    = g_stage[k-1].r_p;
            assign w_vin    = g_stage[k-1].r_v;
        end

        assign w_sa = w_a[k*BLOCK +: BLOCK];
        assign w_sb = w_b[k*BLOCK +: BLOCK];
        assign w_g  = w_sa & w_sb;
        assign w_p  = w_sa | w_sb;

        // Each carry is a flat sum of products over (g, p, cin); no carry feeds another.
        always_comb begin : p_lookahead
            logic t;
            w_c    = '0;
            w_c[0] = w_cin;
            for (int i = 0; i < int'(BLOCK); i++) begin
                t = w_cin;
                for (int m = 0; m <= i; m++) begin
                    t = t & w_p[m];
                end
                w_c[i+1] = t;
                for (int j = 0; j <= i; j++) begin
                    t = w_g[j];
                    for (int m = j + 1; m <= i; m++) begin
                        t = t & w_p[m];
                    end
                    w_c[i+1] = w_c[i+1] | t;
                end
            end
            w_ps = &w_p;
            w_gs = 1'b0;
            for (int j = 0; j < int'(BLOCK); j++) begin
                t = w_g[j];
                for (int m = j + 1; m < int'(BLOCK); m++) begin
                    t = t & w_p[m];
                end
                w_gs = w_gs | t;
            end
        end

        always_comb begin
            w_sum_nxt                    = w_sum_in;
            w_sum_nxt[k*BLOCK +: BLOCK]  = w_sa ^ w_sb ^ w_c[BLOCK-1:0];
        end

        always_ff @(posedge iClk) begin
            if (!iRstn) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_g   <= 1'b0;
                r_p   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_v   <= w_vin;
                r_c   <= w_c[BLOCK];
                r_g   <= w_gs | (w_ps & w_gin);
                r_p   <= w_ps & w_pin;
                r_sum <= w_sum_nxt;
            end
        end

        if (k < NSTAGE - 1) begin : g_ops
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge iClk) begin
                if (!iRstn) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a;
                    r_b <= w_b;
                end
            end
        end else begin : g_last
            logic r_ovf;
            logic w_unused_ops;

            assign w_unused_ops = ^{w_a, w_b};

            // Overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge iClk) begin
                if (!iRstn) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_c[BLOCK-1] ^ w_c[BLOCK];
                end
            end
        end
    end

    assign w_adv      = ~g_stage[NSTAGE-1].r_v | iReady;
    assign oReady     = w_adv;
    assign oValid     = g_stage[NSTAGE-1].r_v;
    assign oSum       = g_stage[NSTAGE-1].r_sum;
    assign oCarryOut  = g_stage[NSTAGE-1].r_c;
    assign oOverflow  = g_stage[NSTAGE-1].g_last.r_ovf;
    assign oGen       = g_stage[NSTAGE-1].r_g;
    assign oPropagate = g_stage[NSTAGE-1].r_p;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three instances (BLOCK 8, 32, 4) checked every cycle
// against an arithmetic scoreboard model.
module tb_pipelined_cla_adder;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         gen;
        logic         prop;
        int           acc;
        bit           stalled;
        bit           seen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         i_valid;
    logic         i_sub;
    logic         i_cin;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [2:0]   i_ready;
    logic [2:0]   o_ready;
    logic [2:0]   o_valid;
    logic [2:0]   o_cout;
    logic [2:0]   o_ovf;
    logic [2:0]   o_gen;
    logic [2:0]   o_prop;
    logic [W-1:0] o_sum [3];

    exp_t q [3][$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipelined_cla_adder #(.WIDTH(W), .BLOCK(8)) u_b8 (
        .iClk(clk), .iRstn(rstn), .iValid(i_valid), .oReady(o_ready[0]), .iA(i_a), .iB(i_b),
        .iSub(i_sub), .iCarryIn(i_cin), .oValid(o_valid[0]), .iReady(i_ready[0]),
        .oSum(o_sum[0]), .oCarryOut(o_cout[0]), .oOverflow(o_ovf[0]), .oGen(o_gen[0]),
        .oPropagate(o_prop[0])
    );
    pipelined_cla_adder #(.WIDTH(W), .BLOCK(32)) u_b32 (
        .iClk(clk), .iRstn(rstn), .iValid(i_valid), .oReady(o_ready[1]), .iA(i_a), .iB(i_b),
        .iSub(i_sub), .iCarryIn(i_cin), .oValid(o_valid[1]), .iReady(i_ready[1]),
        .oSum(o_sum[1]), .oCarryOut(o_cout[1]), .oOverflow(o_ovf[1]), .oGen(o_gen[1]),
        .oPropagate(o_prop[1])
    );
    pipelined_cla_adder #(.WIDTH(W), .BLOCK(4)) u_b4 (
        .iClk(clk), .iRstn(rstn), .iValid(i_valid), .oReady(o_ready[2]), .iA(i_a), .iB(i_b),
        .iSub(i_sub), .iCarryIn(i_cin), .oValid(o_valid[2]), .iReady(i_ready[2]),
        .oSum(o_sum[2]), .oCarryOut(o_cout[2]), .oOverflow(o_ovf[2]), .oGen(o_gen[2]),
        .oPropagate(o_prop[2])
    );

    function automatic int nstage(int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W:0]   nocin;
        bb        = sub ? ~b : b;
        full      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
        nocin     = {1'b0, a} + {1'b0, bb};
        e.sum     = full[W-1:0];
        e.cout    = full[W];
        e.ovf     = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        e.gen     = nocin[W];
        e.prop    = &(a | bb);
        e.acc     = 0;
        e.stalled = 1'b0;
        e.seen    = 1'b0;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pin_model(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin,
                             logic [W-1:0] sum, logic [3:0] flags);
        exp_t e;
        e = model(a, b, sub, cin);
        chk("model_pin", {e.sum, e.cout, e.ovf, e.gen, e.prop}, {sum, flags});
    endtask

    // Scoreboard: sample at the falling edge, act on what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                q[d].delete();
            end else begin
                chk($sformatf("ready%0d", d), {63'd0, o_ready[d]},
                    {63'd0, !(o_valid[d] && !i_ready[d])});
                if (!o_ready[d]) begin
                    for (int j = 0; j < q[d].size(); j++) q[d][j].stalled = 1'b1;
                end
                if (o_valid[d]) begin
                    if (q[d].size() == 0) begin
                        chk($sformatf("spurious%0d", d), 64'd1, 64'd0);
                    end else begin
                        e = q[d][0];
                        chk($sformatf("result%0d", d),
                            {o_sum[d], o_cout[d], o_ovf[d], o_gen[d], o_prop[d]},
                            {e.sum, e.cout, e.ovf, e.gen, e.prop});
                        if (!e.seen && !e.stalled)
                            chk($sformatf("latency%0d", d), 64'(cyc - e.acc),
                                64'(nstage(d) - 1));
                        q[d][0].seen = 1'b1;
                        if (i_ready[d]) void'(q[d].pop_front());
                    end
                end
                if (i_valid && o_ready[d]) begin
                    e     = model(i_a, i_b, i_sub, i_cin);
                    e.acc = cyc + 1;
                    q[d].push_back(e);
                end
            end
        end
    end

    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin);
        bit acc;
        int t;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_cin   = cin;
        t       = 0;
        do begin
            #1;
            acc = o_ready[0];
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
    endtask

    task automatic idle(int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        i_valid = 1'b0;
        t       = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
        idle(2);
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_out%0d", d),
                {o_valid[d], o_sum[d], o_cout[d], o_ovf[d], o_gen[d], o_prop[d]}, 64'd0);
        end
    endtask

    initial begin
        int bp;
        bit acc;
        rstn    = 1'b0;
        i_valid = 1'b0;
        i_sub   = 1'b0;
        i_cin   = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_ready = 3'b111;

        // Hand-computed expectations: {sum, cout, ovf, gen, prop}.
        pin_model(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 4'b0000);
        pin_model(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b1001);
        pin_model(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0000);
        pin_model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0100);
        pin_model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1110);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rstn = 1'b1;
        idle(1);

        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        drain();
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        drain();

        // Backpressure on the BLOCK=8 instance mid-stream.
        bp = 0;
        for (int i = 1; i <= 8; i++) begin
            i_valid = 1'b1;
            i_a     = W'(i);
            i_b     = W'(i);
            i_sub   = 1'b0;
            i_cin   = 1'b0;
            acc     = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                i_ready[0] = !(bp >= 4 && bp < 7);
                #1;
                acc = o_ready[0];
                @(posedge clk);
                #1;
                bp++;
            end
            if (!acc) chk("bp_timeout", 64'd0, 64'd1);
        end
        i_valid    = 1'b0;
        i_ready[0] = 1'b1;
        drain();

        // Bubbles.
        send(32'd10, 32'd20, 1'b0, 1'b0);
        idle(1);
        send(32'd30, 32'd40, 1'b0, 1'b0);
        idle(1);
        drain();

        // Reset with operations in flight.
        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0);
        send(32'd300, 32'd3, 1'b0, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        rstn = 1'b1;
        idle(14);
        send(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic accelerator datapath.
- The WIDTH-bit operation is split into WIDTH/BLOCK slices, with one slice resolved per pipeline stage.
- Each slice uses per-bit generate (a&b) and propagate (a|b) and block-level lookahead.
- Carry ripples between stages through registers. Throughput is one operation per cycle under a valid/ready handshake.
- Also exports full-word group generate/propagate so that wider adders can be cascaded.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per pipeline stage; must be ≥1 and ≤WIDTH.
- Derived NSTAGE = WIDTH/BLOCK; this is the latency in cycles.

Ports:
- iClk  input  1  clock; rising edge.
- iRstn  input  1  reset; synchronous, active-low.
- iValid  input  1  input operation valid.
- oReady  output  1  block can accept; the transfer occurs when iValid & oReady at a rising edge.
- iA  input  WIDTH  operand A.
- iB  input  WIDTH  operand B.
- iSub  input  1  0: A+B+iCarryIn; 1: A−B (A+~B+1, iCarryIn ignored).
- iCarryIn  input  1  carry into bit 0 for add mode.
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts; result consumed on oValid & iReady.
- oSum  output  WIDTH  result.
- oCarryOut  output  1  carry out of the MSB. In sub mode, 1 means no borrow (A ≥ B unsigned).
- oOverflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- oGen  output  1  full-word group generate of (A, B') with B' = iSub ? ~B : B.
- oPropagate  output  1  full-word group propagate: AND of all (a|b') bits.

Behaviour:
- Reset: iRstn=0 at a rising edge clears all stage valid bits and all data/skew registers.
  - oValid=0, oSum=0, oCarryOut=0, oOverflow=0, oGen=0, oPropagate=0.
  - oReady=1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight operation; nothing is emitted afterwards.
- Pipeline advance: adv = ~oValid | iReady. oReady = adv (combinational from oValid/iReady only; no path from iValid).
- Advance cycle: every stage register loads from its predecessor. Stage 0 loads the input, with valid = iValid.
- Stall cycle (adv=0): all stage registers hold; the output is stable while oValid & ~iReady.
- Bubbles: iValid=0 on an advance cycle inserts valid=0. Bubbles collapse only when oValid=0 at the output.
- Stage k (0..NSTAGE−1) computes bits [k*BLOCK +: BLOCK]:
  - Carry-in is the registered carry from stage k−1. Stage 0 uses iSub ? 1 : iCarryIn.
  - Within the slice: bit g=a&b', p=a|b', sum=a^b'^c.
  - Slice carries come from lookahead over (g,p), not a ripple chain.
- Operand skew: upper operand slices are delayed in registers until their stage; lower result slices are delayed until output. All slices of one operation emerge together.
- Latency: with iReady=1 continuously, a result accepted at edge t appears with oValid=1 after edge t+NSTAGE−1. It is visible NSTAGE cycles after acceptance; NSTAGE=1 means a registered output one cycle later.
- oOverflow uses the carry into bit WIDTH−1 and oCarryOut.
- oGen/oPropagate are accumulated stage by stage and are independent of the carry-in:
  - G_acc = G_slice | (P_slice & G_acc)
  - P_acc = P_slice & P_acc
- Ordering: results leave in acceptance order; none are dropped or duplicated under any iReady pattern.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via oCarryOut.
- Simultaneous accept and emit in the same cycle is legal and sustains one op/cycle.

Test Plan:
- Reset, then add with iA=0x0000_0001, iB=0x0000_0002, iCarryIn=0, iReady=1 (WIDTH=32, BLOCK=8). Require:
  - oSum=0x0000_0003, oCarryOut=0, oOverflow=0.
  - oValid rises exactly 4 cycles after acceptance.
- Full carry ripple across all stages: iA=0xFFFF_FFFF, iB=0, iCarryIn=1. Require oSum=0, oCarryOut=1, oGen=0, oPropagate=1, oOverflow=0.
- Subtract and signed overflow:
  - iSub=1, iA=5, iB=7 → oSum=0xFFFF_FFFE, oCarryOut=0.
  - iSub=0, iA=0x7FFF_FFFF, iB=1 → oSum=0x8000_0000, oOverflow=1.
- Backpressure: stream 8 back-to-back ops with iA=i, iB=i (i=1..8), holding iReady=0 for 3 cycles mid-stream. Require:
  - oReady=0 during the stall whenever oValid=1.
  - Outputs 2,4,…,16 in order, none lost or duplicated, held stable while stalled.
- Bubbles: iValid pattern 1,0,1,0 with iReady=1 → oValid pattern 1,0,1,0 with matching results.
- Reset with 3 ops in flight: assert iRstn=0 for 1 cycle. Require all outputs 0 and oValid=0 afterwards; no stale result ever appears.
- Repeat the first three scenarios with BLOCK=32 (NSTAGE=1, latency 1) and BLOCK=4 (NSTAGE=8, latency 8).
